// File: rtl/router_fifo.sv
// Per-port output FIFO of the 1x3 router: stores {header flag, byte}, returns bytes on
// read and tracks packet boundaries from the header length field to pulse pkt_end.
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             pkt_end
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH:0] mem [DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic [6:0]     count;
  logic           lfd_d;
  logic [WIDTH:0] rd_word;
  logic           do_wr, do_rd;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_wr   = write_enb && !full;
  assign do_rd   = read_enb && !empty;
  assign rd_word = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      lfd_d    <= 1'b0;
      data_out <= '0;
      pkt_end  <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      lfd_d    <= 1'b0;
      data_out <= '0;
      pkt_end  <= 1'b0;
    end else begin
      // The header byte reaches data_in one cycle after lfd_state.
      lfd_d   <= lfd_state;
      pkt_end <= 1'b0;
      if (do_wr) begin
        mem[wr_ptr[AW-1:0]] <= {lfd_d, data_in};
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_rd) begin
        data_out <= rd_word[WIDTH-1:0];
        rd_ptr   <= rd_ptr + PTR_ONE;
        if (rd_word[WIDTH]) begin
          // Payload length plus the trailing parity byte.
          count <= {1'b0, rd_word[7:2]} + 7'd1;
        end else if (count != 7'd0) begin
          count   <= count - 7'd1;
          pkt_end <= (count == 7'd1);
        end
      end
    end
  end
endmodule

// File: doc/router_fifo.md
# router_fifo

Per-port output FIFO of the 1x3 router. It sits directly downstream of the packet register stage: it stores the header, payload and parity bytes that stage drives on its byte output, and tags each header with the header-load state. It returns bytes to the destination client on read requests and tracks packet boundaries from the stored header length. `full` and `empty` feed back to the router controller.

## Interface
- DEPTH, 16, number of entries; must be a power of two, at least 4
- WIDTH, 8, data byte width; a header-flag bit is added internally, so stored words are WIDTH+1 bits
- clock  input  1  rising-edge clock for all state
- reset  input  1  synchronous, active-high; clears all state
- soft_reset  input  1  synchronous, active-high; per-port flush after the controller's read timeout
- write_enb  input  1  write request
- read_enb  input  1  read request from the destination client
- lfd_state  input  1  controller's header-load state
- data_in  input  WIDTH  byte from the packet register stage
- data_out  output  WIDTH  registered read data
- full  output  1  no free entry
- empty  output  1  no stored entry
- pkt_end  output  1  one-cycle pulse when the last byte (parity) of a packet is read

## Operation
- One clock; reset is synchronous and active-high.
- **Header flag.** `lfd_d` is `lfd_state` registered once; it lines up with the header byte, which appears on the register stage's output one cycle after `lfd_state`.
- **Write.** When `write_enb && !full`, `{lfd_d, data_in}` is written at `wr_ptr`, and `wr_ptr` increments. When `full`, the write is dropped and no state changes.
- **Read.** When `read_enb && !empty`:
  - `data_out <=` the byte bits of `mem[rd_ptr]`, and `rd_ptr` increments.
  - If the word's flag bit is 1: `count <= data[7:2] + 1` (payload length plus parity byte), 7-bit.
  - If the flag bit is 0 and `count > 0`: `count` decrements.
  - If the flag bit is 0 and `count == 0` (stray byte): the byte is still output and `count` stays 0.
- **pkt_end** is registered. It is 1 in the cycle after a read that moves `count` from 1 to 0; otherwise 0.
- When `empty` is 1, `read_enb` has no effect: `data_out` holds its value and `pkt_end` is 0.
- **Pointers.** `wr_ptr` and `rd_ptr` are log2(DEPTH)+1 bits wide: index bits plus a wrap bit. Indices wrap from DEPTH-1 to 0.
  - `empty` = pointers equal.
  - `full` = index bits equal and wrap bits differ.
  - Both flags are decoded combinationally from the registered pointers.
- **Simultaneous read and write.** Both are evaluated against the pre-edge flags.
  - Full: the read proceeds, the write is dropped; `full` is 0 next cycle.
  - Empty: the write proceeds, the read is ignored; `empty` is 0 next cycle.
  - Otherwise both proceed and occupancy is unchanged.
- **reset** clears memory, pointers, `count`, `lfd_d`, `data_out` (0) and `pkt_end` (0). Resulting flags: `empty`=1, `full`=0.
- **soft_reset** (when `reset`=0) clears pointers, `count`, `lfd_d`, `data_out` and `pkt_end`. Memory contents are kept but are unreachable. Any read or write in the same cycle is discarded.
- Priority: `reset` > `soft_reset` > read/write.

## Timing
- Write to visibility: a word written at edge N makes `empty` 0 after edge N. The earliest read is sampled at edge N+1, with data on `data_out` after edge N+1.
- Read latency: 1 cycle from a sampled `read_enb` to `data_out`.
- `pkt_end` asserts after the same edge that presents the parity byte, for exactly one cycle.
- Flags change only on clock edges, through the pointers. Max occupancy is DEPTH.
- Reset or soft reset mid-packet: effective after the edge; the next cycle shows `empty`=1, `data_out`=0, `count`=0.

## Test plan
- **Reset.** Assert `reset` 2 cycles -> `empty`=1, `full`=0, `data_out`=0x00, `pkt_end`=0.
- **Single packet.** Write header 0x0D (length 3) with `lfd_d`=1, then 0x11, 0x22, 0x33 and parity 0x1F; read 5 -> `data_out` sequence 0x0D, 0x11, 0x22, 0x33, 0x1F. `pkt_end`=1 only in the cycle 0x1F appears.
- **Fill and wrap.**
  - 16 writes -> `full`=1; a 17th write of 0xAA is dropped.
  - 16 reads -> the original order returns and `empty`=1.
  - Repeat with pointers offset by 5 -> order is correct across the index wrap.
- **Simultaneous events.**
  - Full plus read+write -> one byte out, write dropped, `full`=0 next cycle.
  - Empty plus read+write -> `data_out` unchanged, `empty`=0 next cycle.
  - Half-full plus read+write -> occupancy unchanged.
- **Soft reset mid-packet.** After 2 of 5 bytes are read, pulse `soft_reset` -> `empty`=1, `data_out`=0x00, no `pkt_end`. The next packet reads correctly.
- **Stray byte.** Read a non-header byte with `count`=0 -> the byte appears on `data_out`, `count` stays 0, `pkt_end` stays 0.
